// File: rtl/sb_config_loader.sv
// Byte-serial configuration loader: assembles prog words for a row of switch
// boxes into a shadow bank, verifies the frame XOR, then commits atomically.
module sb_config_loader #(
  parameter int NUM_SB = 4,
  parameter int ADDR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [7:0]             cfg_data,
  output logic [32*NUM_SB-1:0]   prog_out,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_COUNT, S_DATA, S_CHECK, S_COMMIT
  } state_e;

  localparam logic [7:0] SYNC  = 8'hA5;
  localparam int         REM_W = ADDR_W + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [1:0]          lane_q, lane_d;
  logic [7:0]          xor_q, xor_d;
  logic [31:0]         shadow_q [NUM_SB];
  logic [31:0]         shadow_d [NUM_SB];
  logic [32*NUM_SB-1:0] prog_q, prog_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic       xfer;
  logic       restore;
  logic [1:0] lane_sel;
  logic [8:0] span;

  assign xfer     = cfg_valid && cfg_ready;
  // Byte 0 of a word lands in the top lane, so the lane index is inverted.
  assign lane_sel = ~lane_q;
  assign span     = 9'(ptr_q) + 9'(cfg_data);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    lane_d   = lane_q;
    xor_d    = xor_q;
    shadow_d = shadow_q;
    prog_d   = prog_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    restore  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (xfer && cfg_data == SYNC) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (xfer) begin
          if (cfg_data >= 8'(NUM_SB)) begin
            err_d   = 1'b1;
            restore = 1'b1;
            state_d = S_IDLE;
          end else begin
            ptr_d   = cfg_data[ADDR_W-1:0];
            xor_d   = cfg_data;
            state_d = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        if (xfer) begin
          xor_d = xor_q ^ cfg_data;
          if (cfg_data == 8'd0 || span > 9'(NUM_SB)) begin
            err_d   = 1'b1;
            restore = 1'b1;
            state_d = S_IDLE;
          end else begin
            rem_d   = cfg_data[REM_W-1:0];
            lane_d  = 2'd0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          xor_d = xor_q ^ cfg_data;
          shadow_d[ptr_q][{lane_sel, 3'b000} +: 8] = cfg_data;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            ptr_d = ptr_q + ADDR_W'(1);
            rem_d = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (cfg_data == xor_q) begin
            state_d = S_COMMIT;
          end else begin
            err_d   = 1'b1;
            restore = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        for (int i = 0; i < NUM_SB; i++) prog_d[32*i +: 32] = shadow_q[i];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A rejected frame must not leave words behind for the next commit.
    if (restore) begin
      for (int i = 0; i < NUM_SB; i++) shadow_d[i] = prog_q[32*i +: 32];
    end
  end

  // NOTE: the shadow bank is reset explicitly; it is committed as a whole, so
  // any word left undefined would reach prog_out on the first partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      lane_q  <= '0;
      xor_q   <= '0;
      for (int i = 0; i < NUM_SB; i++) shadow_q[i] <= '0;
      prog_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      lane_q   <= lane_d;
      xor_q    <= xor_d;
      shadow_q <= shadow_d;
      prog_q   <= prog_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign prog_out  = prog_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign busy      = (state_q != S_IDLE);
  assign cfg_ready = (state_q != S_COMMIT);

endmodule

// File: tb/tb_sb_config_loader.sv
// Bench for sb_config_loader: table of frames with a done/err scoreboard,
// plus hand sequences for handshake gaps and reset in the middle of a frame.
module tb_sb_config_loader;

  localparam int NUM_SB = 4;
  localparam int ADDR_W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [7:0]   cfg_data;
  logic [127:0] prog_out;
  logic         cfg_done;
  logic         cfg_err;
  logic         busy;

  sb_config_loader #(.NUM_SB(NUM_SB), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .prog_out  (prog_out),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [191:0] b;        // frame bytes, first byte leftmost of the len used
    int           len;
    int           err_idx;  // byte after which cfg_err is due, -1 for a good frame
    logic [127:0] exp;      // prog_out expected once the frame resolves
  } vec_t;

  typedef struct packed {
    logic         is_err;
    logic [127:0] prog;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int len, input logic [191:0] b, input int err_idx,
                              input logic [127:0] exp);
    vec_t v;
    v.b = b; v.len = len; v.err_idx = err_idx; v.exp = exp;
    return v;
  endfunction

  // Scoreboard consumer: every done/err pulse must match the next expectation.
  always @(negedge clk) begin
    if (!rst && (cfg_done || cfg_err)) begin
      if (sb_q.size() == 0) begin
        check("spurious_event", 128'({cfg_done, cfg_err}), 128'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("event_kind", 128'({cfg_done, cfg_err}), e.is_err ? 128'd1 : 128'd2);
        check("prog_at_event", prog_out, e.prog);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    cfg_data  = b;
    cfg_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
  endtask

  task automatic send_vec(input vec_t v, input bit gaps);
    exp_t e;
    e.is_err = (v.err_idx >= 0);
    e.prog   = v.exp;
    sb_q.push_back(e);
    for (int k = 0; k < v.len; k++) begin
      send_byte(v.b[8*(v.len-1-k) +: 8]);
      check("err_timing", 128'(cfg_err), 128'(k == v.err_idx));
      if (v.err_idx < 0 && k == v.len - 1) begin
        check("commit_ready_low", 128'(cfg_ready), 128'd0);
        check("no_early_done", 128'(cfg_done), 128'd0);
        @(negedge clk);
        check("done_pulse", 128'(cfg_done), 128'd1);
        check("ready_after_commit", 128'(cfg_ready), 128'd1);
      end
      if (gaps && k < v.len - 1) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    wait_drain();
    @(negedge clk);
    check("idle_busy", 128'(busy), 128'd0);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;

    vecs[0] = mk(8, 192'({8'hA5, 8'h01, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08}), -1,
                 {32'h0, 32'h0, 32'h12345678, 32'h0});
    vecs[1] = mk(8, 192'({8'hA5, 8'h01, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23}), 7,
                 {32'h0, 32'h0, 32'h12345678, 32'h0});
    vecs[2] = mk(8, 192'({8'hA5, 8'h02, 8'h01, 8'hCA, 8'hFE, 8'h00, 8'h01, 8'h36}), -1,
                 {32'h0, 32'hCAFE0001, 32'h12345678, 32'h0});
    vecs[3] = mk(20, 192'({8'hA5, 8'h00, 8'h04, 32'h11111111, 32'h22222222, 32'h33333333,
                           32'h44444444, 8'h04}), -1,
                 {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    vecs[4] = mk(6, 192'({8'hA5, 8'h04, 8'h01, 8'h12, 8'h34, 8'h56}), 1,
                 {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    vecs[5] = mk(3, 192'({8'hA5, 8'h03, 8'h02}), 2,
                 {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    vecs[6] = mk(3, 192'({8'hA5, 8'h00, 8'h00}), 2,
                 {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    vecs[7] = mk(10, 192'({8'h3C, 8'hFF, 8'hA5, 8'h03, 8'h01, 8'h0F, 8'h0E, 8'h0D, 8'h0C,
                           8'h02}), -1,
                 {32'h0F0E0D0C, 32'h33333333, 32'h22222222, 32'h11111111});
    vecs[8] = mk(10, 192'({8'h3C, 8'hFF, 8'hA5, 8'h01, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78,
                           8'h08}), -1,
                 {32'h0, 32'h0, 32'h12345678, 32'h0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_prog", prog_out, 128'd0);
    check("reset_ready", 128'(cfg_ready), 128'd1);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_done", 128'(cfg_done), 128'd0);
    check("reset_err", 128'(cfg_err), 128'd0);

    for (int i = 0; i < 8; i++) send_vec(vecs[i], 1'b0);

    // Stray bytes plus random valid gaps must give the plain single-word result.
    do_reset();
    send_vec(vecs[8], 1'b1);

    // Reset after the second data byte discards the frame and clears prog_out.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    check("mid_frame_busy", 128'(busy), 128'd1);
    do_reset();
    check("mid_reset_prog", prog_out, 128'd0);
    check("mid_reset_busy", 128'(busy), 128'd0);
    check("mid_reset_flags", 128'({cfg_done, cfg_err}), 128'd0);
    repeat (3) @(negedge clk);
    check("no_event_after_reset", 128'({cfg_done, cfg_err}), 128'd0);
    send_vec(vecs[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
